// File: rtl/lampFPU_pkg.sv
// Shared bfloat16 FPU definitions: format widths, special encodings,
// divider sequencer states and the operand unpack/classify helper.
package lampFPU_pkg;

    localparam int unsigned LAMP_FLOAT_DW     = 16;
    localparam int unsigned LAMP_FLOAT_E_DW   = 8;
    localparam int unsigned LAMP_FLOAT_F_DW   = 7;
    localparam int unsigned LAMP_FLOAT_E_BIAS = 127;
    localparam int unsigned LAMP_EXT_E_DW     = LAMP_FLOAT_E_DW + 2;
    localparam int unsigned LAMP_SIG_DW       = LAMP_FLOAT_F_DW + 1;
    localparam int unsigned LAMP_FD_DW        = 16;

    localparam logic [LAMP_FLOAT_DW-1:0] LAMP_QNAN = 16'h7FC0;
    localparam logic [LAMP_FLOAT_DW-1:0] LAMP_INF  = 16'h7F80;

    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, NORM} div_state_t;

    typedef struct packed {
        logic                       sign;
        logic [LAMP_FLOAT_E_DW-1:0] exp;
        logic [LAMP_FLOAT_F_DW-1:0] frac;
        logic                       is_zero;
        logic                       is_inf;
        logic                       is_nan;
    } lamp_operand_t;

    // Denormals (exp == 0) classify as zero: the FPU flushes them.
    function automatic lamp_operand_t FUNC_splitOperand(input logic [LAMP_FLOAT_DW-1:0] op);
        lamp_operand_t r;
        r.sign    = op[LAMP_FLOAT_DW-1];
        r.exp     = op[LAMP_FLOAT_DW-2 -: LAMP_FLOAT_E_DW];
        r.frac    = op[LAMP_FLOAT_F_DW-1:0];
        r.is_zero = (r.exp == '0);
        r.is_inf  = (r.exp == '1) && (r.frac == '0);
        r.is_nan  = (r.exp == '1) && (r.frac != '0);
        return r;
    endfunction

endpackage

// File: rtl/lamp_fpu_rnd_pack.sv
// Round-to-nearest-even on a normalized significand, then clamp the exponent
// to inf/zero and pack a bfloat16 result. Purely combinational.
module lamp_fpu_rnd_pack
    import lampFPU_pkg::*;
(
    input  logic                              sign,
    input  logic signed [LAMP_EXT_E_DW-1:0]   exp,
    input  logic        [LAMP_FLOAT_F_DW-1:0] mant,
    input  logic                              guard,
    input  logic                              sticky,
    output logic        [LAMP_FLOAT_DW-1:0]   res_c,
    output logic                              overflow_c,
    output logic                              underflow_c
);

    localparam logic signed [LAMP_EXT_E_DW-1:0] EXP_MAX = LAMP_EXT_E_DW'((1 << LAMP_FLOAT_E_DW) - 1);
    localparam logic signed [LAMP_EXT_E_DW-1:0] EXP_MIN = LAMP_EXT_E_DW'(0);

    logic                             round_up;
    logic        [LAMP_SIG_DW-1:0]    mant_rnd;
    logic signed [LAMP_EXT_E_DW-1:0]  exp_fin;

    always_comb begin
        round_up    = guard & (sticky | mant[0]);
        mant_rnd    = {1'b0, mant} + LAMP_SIG_DW'(round_up);
        // A carry-out leaves the stored fraction at zero and bumps the exponent.
        exp_fin     = exp + LAMP_EXT_E_DW'(mant_rnd[LAMP_FLOAT_F_DW]);
        overflow_c  = 1'b0;
        underflow_c = 1'b0;
        res_c       = {sign, exp_fin[LAMP_FLOAT_E_DW-1:0], mant_rnd[LAMP_FLOAT_F_DW-1:0]};
        if (exp_fin >= EXP_MAX) begin
            overflow_c = 1'b1;
            res_c      = {sign, LAMP_INF[LAMP_FLOAT_DW-2:0]};
        end else if (exp_fin <= EXP_MIN) begin
            underflow_c = 1'b1;
            res_c       = {sign, {(LAMP_FLOAT_DW-1){1'b0}}};
        end
    end

endmodule

// File: rtl/lamp_fpu_div_seq.sv
// bfloat16 divide sequencer: resolves special operands locally, otherwise
// drives the Goldschmidt fractional divider and normalizes/rounds its quotient.
module lamp_fpu_div_seq
    import lampFPU_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       doDiv_i,
    input  logic [LAMP_FLOAT_DW-1:0]   op1_i,
    input  logic [LAMP_FLOAT_DW-1:0]   op2_i,
    output logic [LAMP_FLOAT_DW-1:0]   res_o,
    output logic                       valid_o,
    output logic                       busy_o,
    output logic                       invalid_o,
    output logic                       divByZero_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    output logic                       fdDoDiv_o,
    output logic [LAMP_SIG_DW-1:0]     fdN_o,
    output logic [LAMP_SIG_DW-1:0]     fdD_o,
    input  logic [LAMP_FD_DW-1:0]      fdRes_i,
    input  logic                       fdValid_i
);

    div_state_t                       state, state_nxt;
    logic [LAMP_FLOAT_DW-1:0]         op1_r, op1_nxt, op2_r, op2_nxt;
    logic                             sign_r, sign_nxt;
    logic signed [LAMP_EXT_E_DW-1:0]  exp_r, exp_nxt;
    logic [LAMP_FD_DW-2:0]            q_r, q_nxt;
    logic [LAMP_FLOAT_DW-1:0]         res_nxt;
    logic                             valid_nxt, busy_nxt, fd_do_nxt;
    logic                             inv_nxt, dbz_nxt, ovf_nxt, unf_nxt;
    logic [LAMP_SIG_DW-1:0]           fd_n_nxt, fd_d_nxt;
    lamp_operand_t                    a, b;

    // The quotient lies in (0.5, 2), so its integer MSB is always clear.
    logic unused_fd_msb;
    assign unused_fd_msb = fdRes_i[LAMP_FD_DW-1];

    assign a = FUNC_splitOperand(op1_r);
    assign b = FUNC_splitOperand(op2_r);

    // Normalize the Q2.14 quotient to 1.x; q < 1 costs one exponent step.
    logic [LAMP_FLOAT_F_DW-1:0]       norm_mant;
    logic                             norm_guard, norm_sticky;
    logic signed [LAMP_EXT_E_DW-1:0]  norm_exp;

    always_comb begin
        if (q_r[14]) begin
            norm_mant   = q_r[13:7];
            norm_guard  = q_r[6];
            norm_sticky = |q_r[5:0];
            norm_exp    = exp_r;
        end else begin
            norm_mant   = q_r[12:6];
            norm_guard  = q_r[5];
            norm_sticky = |q_r[4:0];
            norm_exp    = exp_r - LAMP_EXT_E_DW'(1);
        end
    end

    logic [LAMP_FLOAT_DW-1:0] pack_res;
    logic                     pack_ovf, pack_unf;

    lamp_fpu_rnd_pack u_rnd_pack (
        .sign        (sign_r),
        .exp         (norm_exp),
        .mant        (norm_mant),
        .guard       (norm_guard),
        .sticky      (norm_sticky),
        .res_c       (pack_res),
        .overflow_c  (pack_ovf),
        .underflow_c (pack_unf)
    );

    always_comb begin
        state_nxt = state;
        op1_nxt   = op1_r;
        op2_nxt   = op2_r;
        sign_nxt  = sign_r;
        exp_nxt   = exp_r;
        q_nxt     = q_r;
        res_nxt   = res_o;
        inv_nxt   = invalid_o;
        dbz_nxt   = divByZero_o;
        ovf_nxt   = overflow_o;
        unf_nxt   = underflow_o;
        valid_nxt = 1'b0;
        fd_do_nxt = 1'b0;
        fd_n_nxt  = '0;
        fd_d_nxt  = '0;

        case (state)
            IDLE: begin
                if (doDiv_i) begin
                    op1_nxt   = op1_i;
                    op2_nxt   = op2_i;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                sign_nxt = a.sign ^ b.sign;
                exp_nxt  = LAMP_EXT_E_DW'({2'b00, a.exp}) - LAMP_EXT_E_DW'({2'b00, b.exp})
                         + LAMP_EXT_E_DW'(LAMP_FLOAT_E_BIAS);
                if (a.is_nan || b.is_nan || (a.is_zero && b.is_zero) || (a.is_inf && b.is_inf) ||
                    a.is_inf || b.is_zero || a.is_zero || b.is_inf) begin
                    inv_nxt   = 1'b0;
                    dbz_nxt   = 1'b0;
                    ovf_nxt   = 1'b0;
                    unf_nxt   = 1'b0;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                    if (a.is_nan || b.is_nan) begin
                        res_nxt = LAMP_QNAN;
                    end else if ((a.is_zero && b.is_zero) || (a.is_inf && b.is_inf)) begin
                        res_nxt = LAMP_QNAN;
                        inv_nxt = 1'b1;
                    end else if (a.is_inf) begin
                        res_nxt = {a.sign ^ b.sign, LAMP_INF[LAMP_FLOAT_DW-2:0]};
                    end else if (b.is_zero) begin
                        res_nxt = {a.sign ^ b.sign, LAMP_INF[LAMP_FLOAT_DW-2:0]};
                        dbz_nxt = 1'b1;
                    end else begin
                        res_nxt = {a.sign ^ b.sign, {(LAMP_FLOAT_DW-1){1'b0}}};
                    end
                end else begin
                    fd_do_nxt = 1'b1;
                    fd_n_nxt  = {1'b1, a.frac};
                    fd_d_nxt  = {1'b1, b.frac};
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (fdValid_i) begin
                    q_nxt     = fdRes_i[LAMP_FD_DW-2:0];
                    state_nxt = NORM;
                end
            end
            NORM: begin
                res_nxt   = pack_res;
                inv_nxt   = 1'b0;
                dbz_nxt   = 1'b0;
                ovf_nxt   = pack_ovf;
                unf_nxt   = pack_unf;
                valid_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op1_r       <= '0;
            op2_r       <= '0;
            sign_r      <= 1'b0;
            exp_r       <= '0;
            q_r         <= '0;
            res_o       <= '0;
            valid_o     <= 1'b0;
            busy_o      <= 1'b0;
            invalid_o   <= 1'b0;
            divByZero_o <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            fdDoDiv_o   <= 1'b0;
            fdN_o       <= '0;
            fdD_o       <= '0;
        end else begin
            state       <= state_nxt;
            op1_r       <= op1_nxt;
            op2_r       <= op2_nxt;
            sign_r      <= sign_nxt;
            exp_r       <= exp_nxt;
            q_r         <= q_nxt;
            res_o       <= res_nxt;
            valid_o     <= valid_nxt;
            busy_o      <= busy_nxt;
            invalid_o   <= inv_nxt;
            divByZero_o <= dbz_nxt;
            overflow_o  <= ovf_nxt;
            underflow_o <= unf_nxt;
            fdDoDiv_o   <= fd_do_nxt;
            fdN_o       <= fd_n_nxt;
            fdD_o       <= fd_d_nxt;
        end
    end

endmodule

// File: tb/tb_lamp_fpu_div_seq.sv
// Directed bench for the bfloat16 divide sequencer, with a truncating
// fixed-latency model of the fractional divider.
module tb_lamp_fpu_div_seq;

    localparam int LAT = 3;
    localparam int NV  = 15;

    typedef struct {
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] res;
        logic [3:0]  flags;   // {invalid, divByZero, overflow, underflow}
        bit          special;
    } vec_t;

    logic        clk, rst, doDiv, fdValid;
    logic [15:0] op1, op2, fdRes, res;
    logic        valid, busy, invalid, dbz, ovf, unf, fd_do;
    logic [7:0]  fd_n, fd_d;

    int n_vec = 0, n_fail = 0, n_cmp = 0;
    int valid_cnt = 0, fd_pulses = 0;
    int cd = 0;
    logic [15:0] q_pend;

    lamp_fpu_div_seq dut (
        .clk         (clk),
        .rst         (rst),
        .doDiv_i     (doDiv),
        .op1_i       (op1),
        .op2_i       (op2),
        .res_o       (res),
        .valid_o     (valid),
        .busy_o      (busy),
        .invalid_o   (invalid),
        .divByZero_o (dbz),
        .overflow_o  (ovf),
        .underflow_o (unf),
        .fdDoDiv_o   (fd_do),
        .fdN_o       (fd_n),
        .fdD_o       (fd_d),
        .fdRes_i     (fdRes),
        .fdValid_i   (fdValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid === 1'b1) valid_cnt++;
        if (fd_do === 1'b1) fd_pulses++;
    end

    // Divider model: truncated (n << 14) / d, delivered LAT cycles after the request.
    initial begin
        fdValid = 1'b0;
        fdRes   = 16'hDEAD;
        forever begin
            @(negedge clk);
            fdValid = 1'b0;
            fdRes   = 16'hDEAD;
            if (rst) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        fdValid = 1'b1;
                        fdRes   = q_pend;
                    end
                end
                if (fd_do === 1'b1) begin
                    q_pend = (fd_d != 8'd0) ? 16'((32'(fd_n) << 14) / 32'(fd_d)) : 16'hFFFF;
                    cd     = LAT;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int first_valid = -1;
        int first_issue = -1;
        int f0 = fd_pulses;
        int exp_lat = v.special ? 1 : LAT + 3;
        @(negedge clk);
        op1 = v.op1; op2 = v.op2; doDiv = 1'b1;
        @(negedge clk);
        doDiv = 1'b0;
        for (int k = 1; k <= 40 && first_valid < 0; k++) begin
            @(negedge clk);
            if (fd_do === 1'b1 && first_issue < 0) begin
                first_issue = k;
                check({tag, " fd_operands"}, {fd_n, fd_d}, {1'b1, v.op1[6:0], 1'b1, v.op2[6:0]});
            end
            if (valid === 1'b1) begin
                first_valid = k;
                check({tag, " res"}, res, v.res);
                check({tag, " flags"}, {invalid, dbz, ovf, unf}, v.flags);
                check({tag, " busy_at_valid"}, busy, 0);
            end
        end
        check({tag, " latency"}, first_valid, exp_lat);
        if (v.special) check({tag, " no_fd_request"}, fd_pulses - f0, 0);
        else           check({tag, " issue_cycle"}, first_issue, 1);
        @(negedge clk);
        check({tag, " valid_one_cycle"}, valid, 0);
        check({tag, " res_hold"}, res, v.res);
        n_vec++;
    endtask

    vec_t vecs[NV];

    initial begin
        int v0, f0, first;
        vecs[0]  = '{16'h3FC0, 16'h3F80, 16'h3FC0, 4'b0000, 1'b0};
        vecs[1]  = '{16'h3F80, 16'h4040, 16'h3EAB, 4'b0000, 1'b0};
        vecs[2]  = '{16'h0000, 16'h0000, 16'h7FC0, 4'b1000, 1'b1};
        vecs[3]  = '{16'hC000, 16'h0000, 16'hFF80, 4'b0100, 1'b1};
        vecs[4]  = '{16'h7F00, 16'h0080, 16'h7F80, 4'b0010, 1'b0};
        vecs[5]  = '{16'h0080, 16'h7F00, 16'h0000, 4'b0001, 1'b0};
        vecs[6]  = '{16'h40C0, 16'h4000, 16'h4040, 4'b0000, 1'b0};
        vecs[7]  = '{16'hBF80, 16'h4000, 16'hBF00, 4'b0000, 1'b0};
        vecs[8]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 4'b0000, 1'b1};
        vecs[9]  = '{16'h7F80, 16'hFF80, 16'h7FC0, 4'b1000, 1'b1};
        vecs[10] = '{16'hFF80, 16'h4000, 16'hFF80, 4'b0000, 1'b1};
        vecs[11] = '{16'h8000, 16'h4000, 16'h8000, 4'b0000, 1'b1};
        vecs[12] = '{16'h3F80, 16'h7F80, 16'h0000, 4'b0000, 1'b1};
        vecs[13] = '{16'h0001, 16'h3F80, 16'h0000, 4'b0000, 1'b1};
        vecs[14] = '{16'h7F80, 16'h0000, 16'h7F80, 4'b0000, 1'b1};

        rst = 1'b0; doDiv = 1'b0; op1 = '0; op2 = '0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", {res, invalid, dbz, ovf, unf, valid, busy, fd_do, fd_n, fd_d}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting on the divider.
        @(negedge clk);
        op1 = 16'h3FC0; op2 = 16'h3F80; doDiv = 1'b1;
        @(negedge clk);
        doDiv = 1'b0;
        @(negedge clk);
        check("rst_seq issue", fd_do, 1);
        @(negedge clk);
        check("rst_seq busy_in_wait", busy, 1);
        v0 = valid_cnt;
        rst = 1'b1;
        #1;
        check("rst_seq async_clear", {res, invalid, dbz, ovf, unf, valid, busy, fd_do, fd_n, fd_d}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_seq no_valid", valid_cnt - v0, 0);
        check("rst_seq idle", busy, 0);
        run_op('{16'h4000, 16'h4000, 16'h3F80, 4'b0000, 1'b0}, "post_rst");

        // doDiv held high across two back-to-back operations.
        v0 = valid_cnt; f0 = fd_pulses; first = -1;
        @(negedge clk);
        op1 = 16'h3FC0; op2 = 16'h3F80; doDiv = 1'b1;
        @(negedge clk);
        op1 = 16'h0000; op2 = 16'h0000;
        for (int k = 1; k <= 40 && first < 0; k++) begin
            @(negedge clk);
            if (valid === 1'b1) first = k;
        end
        check("b2b first_latency", first, LAT + 3);
        check("b2b first_res", {res, invalid, dbz, ovf, unf}, {16'h3FC0, 4'b0000});
        @(negedge clk);
        check("b2b second_pending", {valid, busy}, 2'b01);
        @(negedge clk);
        check("b2b second_res", {valid, res, invalid, dbz, ovf, unf}, {1'b1, 16'h7FC0, 4'b1000});
        doDiv = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b valid_count", valid_cnt - v0, 2);
        check("b2b fd_requests", fd_pulses - f0, 1);
        n_vec += 2;

        $display("comparisons made: %0d", n_cmp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
